mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- Parametrised MDIO (IEEE 802.3 clause 22 / clause 45) station-management master.
- Accepts one 32-bit management frame per transaction and generates MDC from the system clock with a programmable divider.
- Serialises the frame MSB-first with an optional preamble, releases the line for turnaround on reads, and returns the 16-bit read data with a one-cycle ready strobe.
- Sits between the register-access controller and the PHY pins.

Parameters:
- DIV, 2, MDC half-period in clk cycles (>=1); one MDIO bit = 2*DIV clk cycles.
- PRE_LEN, 32, preamble length in bits (0..32); 0 = preamble suppression.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous active-low reset; 0 forces IDLE and clears all outputs.
- mdio_start  input  1  start request, sampled only in IDLE.
- t_data  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data/address.
- mdio_in  input  1  serial data from PHY.
- rd_data  output  16  last read data.
- data_rdy  output  1  one-cycle pulse when read completes.
- busy  output  1  transaction in progress.
- mdc  output  1  management clock.
- mdio_oe  output  1  1 = master drives MDIO.
- mdio_out  output  1  serial data to PHY.

Behaviour:
- Reset (async, reset=0): state=IDLE, rd_data=0, data_rdy=0, busy=0, mdc=0, mdio_oe=0, mdio_out=0, counters and shift registers cleared. Reset mid-frame aborts immediately; no data_rdy is issued.
- Transaction type: read when t_data[29]=1 (C22 read OP=10; C45 read OP=11 or post-read-increment OP=10). Otherwise write or address (C45 OP=00).
- Start: in IDLE, mdio_start=1 latches t_data and the read flag. Next cycle busy=1. mdio_start is ignored while busy=1; no queueing.
- States: IDLE -> PRE (skipped if PRE_LEN=0) -> HDR (14 bits, t_data[31:18]) -> TA (2 bits) -> DAT (16 bits) -> IDLE.
- Bit timing: each bit window starts with mdc=0 for DIV cycles, then mdc=1 for DIV cycles. mdio_out/mdio_oe change only at window start (mdc falling or first window). MDC is idle-low, driven only while busy.
- PRE: mdio_oe=1, mdio_out=1 for PRE_LEN windows.
- HDR: mdio_oe=1, mdio_out = latched bit MSB-first.
- TA, write: mdio_oe=1, drive t_data[17:16] (expected 10).
- TA, read: mdio_oe=0 for both TA windows, mdio_out=0.
- DAT, write: drive t_data[15:0] MSB-first, mdio_oe=1.
- DAT, read: mdio_oe=0. mdio_in is sampled on the clk edge where mdc goes 0->1, shifted in MSB-first.
- Completion: after the high phase of the last DAT window, next cycle mdc=0, mdio_oe=0, mdio_out=0, busy=0.
- Read completion: in that same cycle rd_data = assembled 16 bits and data_rdy=1 for exactly one cycle.
- Write completion: rd_data unchanged, no data_rdy.
- Latency, start accept to busy fall: (PRE_LEN+32)*2*DIV + 1 clk cycles.
- A new mdio_start is accepted in the cycle busy falls (IDLE). Back-to-back frames allowed with no idle window.
- Counters: bit counter 6 bits; divider counter wide enough for DIV-1, wraps to 0 at DIV-1.

Test Plan:
- DIV=2, PRE_LEN=32, t_data=32'h5F8A_1234 (C22 write) -> 32 ones then bits 0101_1111_1000_1010_0001_0010_0011_0100 on mdio_out at mdc falling; mdio_oe=1 throughout; busy high 257 cycles; data_rdy never pulses.
- C22 read t_data=32'h6F8A_0000, PHY drives 16'hBEEF on DAT windows -> mdio_oe=0 from TA start; rd_data=16'hBEEF with single-cycle data_rdy coincident with busy fall.
- PRE_LEN=0, DIV=1, C45 address t_data=32'h0086_ABCD -> no preamble, first bit 0 one cycle after start; frame 64 cycles; mdc period 2 clk.
- mdio_start pulsed again mid-frame with different t_data -> ignored, original frame completes unchanged; start held high at busy fall -> second frame begins immediately.
- reset=0 asserted during read DAT bit 5 -> all outputs 0 asynchronously, no data_rdy, rd_data=0; after release IDLE and a fresh read completes correctly.
- C45 read-increment OP=10, ST=00, PHY drives 16'h0001 -> rd_data=16'h0001, data_rdy pulse; mdc low when idle.

Source files
------------

// File: rtl/mdio_master.sv
// MDIO (clause 22 / clause 45) station-management master: serialises one 32-bit
// frame on MDC/MDIO with optional preamble and returns read data with a ready strobe.
module mdio_master #(
    parameter int DIV     = 2,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic [15:0] rd_data,
    output logic        data_rdy,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_oe,
    output logic        mdio_out
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DAT, FIN} state_t;

    localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [5:0]      PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;
    localparam state_t          FIRST    = (PRE_LEN > 0) ? PRE : HDR;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic          phase, phase_n;
    logic [5:0]    bit_cnt, bit_cnt_n;
    logic [31:0]   frame, frame_n;
    logic          is_rd, is_rd_n;
    logic [15:0]   rd_sr, rd_sr_n;
    logic [15:0]   rd_data_n;
    logic          data_rdy_n, busy_n, mdc_n, oe_n, out_n;
    logic [5:0]    bits_last;
    logic          win_end;

    // The counters describe the window position being registered onto the pins, so
    // the pins lag the position by one cycle; that lag is the lead-in cycle after start.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n    = state;
        div_cnt_n  = div_cnt;
        phase_n    = phase;
        bit_cnt_n  = bit_cnt;
        frame_n    = frame;
        is_rd_n    = is_rd;
        rd_sr_n    = rd_sr;
        rd_data_n  = rd_data;
        data_rdy_n = 1'b0;
        busy_n     = 1'b0;
        mdc_n      = 1'b0;
        oe_n       = 1'b0;
        out_n      = 1'b0;
        bits_last  = 6'd15;
        win_end    = 1'b0;

        case (state)
            IDLE: begin
                if (mdio_start) begin
                    frame_n   = t_data;
                    is_rd_n   = t_data[29];
                    busy_n    = 1'b1;
                    div_cnt_n = '0;
                    phase_n   = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = FIRST;
                end
            end

            FIN: begin
                state_n = IDLE;
                if (is_rd) begin
                    rd_data_n  = rd_sr;
                    data_rdy_n = 1'b1;
                end
            end

            default: begin
                busy_n = 1'b1;
                mdc_n  = phase;
                case (state)
                    PRE: begin
                        oe_n      = 1'b1;
                        out_n     = 1'b1;
                        bits_last = PRE_LAST;
                    end
                    HDR: begin
                        oe_n      = 1'b1;
                        out_n     = frame[31];
                        bits_last = 6'd13;
                    end
                    TA: begin
                        oe_n      = !is_rd;
                        out_n     = !is_rd && frame[31];
                        bits_last = 6'd1;
                    end
                    default: begin
                        oe_n      = !is_rd;
                        out_n     = !is_rd && frame[31];
                        bits_last = 6'd15;
                    end
                endcase

                // Sample on the edge that raises MDC.
                if (state == DAT && is_rd && phase && div_cnt == '0)
                    rd_sr_n = {rd_sr[14:0], mdio_in};

                win_end = phase && (div_cnt == DIV_LAST);
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    phase_n   = !phase;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end

                if (win_end) begin
                    if (state != PRE)
                        frame_n = {frame[30:0], 1'b0};
                    if (bit_cnt == bits_last) begin
                        bit_cnt_n = '0;
                        case (state)
                            PRE:     state_n = HDR;
                            HDR:     state_n = TA;
                            TA:      state_n = DAT;
                            default: state_n = FIN;
                        endcase
                    end else begin
                        bit_cnt_n = bit_cnt + 6'd1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            frame    <= '0;
            is_rd    <= 1'b0;
            rd_sr    <= '0;
            rd_data  <= '0;
            data_rdy <= 1'b0;
            busy     <= 1'b0;
            mdc      <= 1'b0;
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_cnt_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            frame    <= frame_n;
            is_rd    <= is_rd_n;
            rd_sr    <= rd_sr_n;
            rd_data  <= rd_data_n;
            data_rdy <= data_rdy_n;
            busy     <= busy_n;
            mdc      <= mdc_n;
            mdio_oe  <= oe_n;
            mdio_out <= out_n;
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (DIV=2/PRE=32 and DIV=1/PRE=0) checked every
// cycle against a cycle-indexed frame model, plus literal expectations per scenario.
module tb_mdio_master;

    localparam int DIV0 = 2;
    localparam int PRE0 = 32;
    localparam int DIV1 = 1;
    localparam int PRE1 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] tdata0, tdata1;
    logic        min0, min1;
    logic [15:0] rd0, rd1;
    logic        rdy0, rdy1, busy0, busy1, mdc0, mdc1, oe0, oe1, out0, out1;

    always #5 clk = ~clk;

    mdio_master #(.DIV(DIV0), .PRE_LEN(PRE0)) dut0 (
        .clk(clk), .reset(reset), .mdio_start(start0), .t_data(tdata0), .mdio_in(min0),
        .rd_data(rd0), .data_rdy(rdy0), .busy(busy0), .mdc(mdc0), .mdio_oe(oe0), .mdio_out(out0)
    );

    mdio_master #(.DIV(DIV1), .PRE_LEN(PRE1)) dut1 (
        .clk(clk), .reset(reset), .mdio_start(start1), .t_data(tdata1), .mdio_in(min1),
        .rd_data(rd1), .data_rdy(rdy1), .busy(busy1), .mdc(mdc1), .mdio_oe(oe1), .mdio_out(out1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    function automatic int pre_of(input int d);
        return (d == 0) ? PRE0 : PRE1;
    endfunction

    // Clock cycles spent in bit windows for one frame.
    function automatic int nlen(input int d);
        return (pre_of(d) + 32) * 2 * div_of(d);
    endfunction

    // Frame model: m_k is the cycle index after the accepting edge. Cycle 1 is the
    // lead-in, cycles 2..n+1 are bit windows, cycle n+2 is completion (idle again).
    bit          m_active [2];
    int          m_k      [2];
    logic [31:0] m_frame  [2];
    bit          m_rd     [2];
    logic [15:0] m_phy    [2];
    logic [15:0] m_last_rd[2];
    logic [15:0] phy_next [2];

    function automatic logic phy_bit(input int d);
        int b;
        if (m_active[d] && m_rd[d] && m_k[d] >= 2 && m_k[d] <= nlen(d) + 1) begin
            b = (m_k[d] - 2) / (2 * div_of(d)) - pre_of(d);
            if (b >= 16) return m_phy[d][31 - b];
        end
        return 1'b1;
    endfunction

    function automatic void expect_out(input int d, output logic [15:0] rd, output logic [4:0] pins);
        int   j, w, b, dv;
        logic rdy, bsy, mc, oe, o;
        dv  = div_of(d);
        rdy = 1'b0; bsy = 1'b0; mc = 1'b0; oe = 1'b0; o = 1'b0;
        rd  = m_last_rd[d];
        if (m_active[d]) begin
            if (m_k[d] == 1) begin
                bsy = 1'b1;
            end else if (m_k[d] <= nlen(d) + 1) begin
                bsy = 1'b1;
                j   = m_k[d] - 2;
                w   = j / (2 * dv);
                mc  = (j % (2 * dv)) >= dv;
                b   = w - pre_of(d);
                if (b < 0) begin
                    oe = 1'b1; o = 1'b1;
                end else if (b < 14 || !m_rd[d]) begin
                    oe = 1'b1; o = m_frame[d][31 - b];
                end
            end else begin
                rdy = m_rd[d];
            end
        end
        pins = {rdy, bsy, mc, oe, o};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d]  = 1'b0;
            m_k[d]       = 0;
            m_last_rd[d] = '0;
        end
        min0 = 1'b1;
        min1 = 1'b1;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    m_active[d]  = 1'b0;
                    m_k[d]       = 0;
                    m_last_rd[d] = '0;
                end
                min0 = 1'b1;
                min1 = 1'b1;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic        st;
                    logic [31:0] td;
                    st = (d == 0) ? start0 : start1;
                    td = (d == 0) ? tdata0 : tdata1;
                    if (!m_active[d] || m_k[d] == nlen(d) + 2) begin
                        m_active[d] = st;
                        if (st) begin
                            m_k[d]     = 1;
                            m_frame[d] = td;
                            m_rd[d]    = td[29];
                            m_phy[d]   = phy_next[d];
                        end
                    end else begin
                        m_k[d]++;
                        if (m_k[d] == nlen(d) + 2 && m_rd[d])
                            m_last_rd[d] = m_phy[d];
                    end
                end
                min0 = phy_bit(0);
                min1 = phy_bit(1);
            end
        end
    end

    int          busy_cnt[2];
    int          rdy_cnt [2];
    int          rise_cnt[2];
    bit          prev_mdc[2];
    logic [63:0] stream  [2];

    // Per-cycle comparison on the falling edge, plus pin observations for literal checks.
    initial begin
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; rdy_cnt[d] = 0; rise_cnt[d] = 0;
            prev_mdc[d] = 1'b0; stream[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [15:0] erd, ard;
                logic [4:0]  ev, av;
                expect_out(d, erd, ev);
                ard = (d == 0) ? rd0 : rd1;
                av  = (d == 0) ? {rdy0, busy0, mdc0, oe0, out0} : {rdy1, busy1, mdc1, oe1, out1};
                check($sformatf("dut%0d_pins(rdy,busy,mdc,oe,out)", d), 64'(av), 64'(ev));
                check($sformatf("dut%0d_rd_data", d), 64'(ard), 64'(erd));
                if (av[3]) busy_cnt[d]++;
                if (av[4]) rdy_cnt[d]++;
                if (av[2] && !prev_mdc[d]) begin
                    rise_cnt[d]++;
                    stream[d] = {stream[d][62:0], av[0]};
                end
                prev_mdc[d] = av[2];
            end
        end
    end

    task automatic wait_k(input int d, input int target, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (m_active[d] && m_k[d] == target) found = 1'b1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    initial begin
        int b, r, f;
        reset  = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        tdata0 = '0;   tdata1 = '0;
        phy_next[0] = '0; phy_next[1] = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_state_dut0", 64'({rd0, rdy0, busy0, mdc0, oe0, out0}), 64'd0);
        check("reset_state_dut1", 64'({rd1, rdy1, busy1, mdc1, oe1, out1}), 64'd0);
        @(posedge clk); #2 reset = 1'b1;

        // C22 write with a second start pulsed mid-frame that must be ignored.
        @(posedge clk); #2;
        tdata0 = 32'h5F8A_1234; start0 = 1'b1;
        b = busy_cnt[0]; r = rdy_cnt[0]; f = rise_cnt[0];
        @(posedge clk); #2 start0 = 1'b0;
        repeat (40) @(posedge clk);
        #2 tdata0 = 32'h6A5A_FFFF; start0 = 1'b1;
        @(posedge clk); #2 start0 = 1'b0;
        wait_k(0, nlen(0) + 2, "write_done");
        @(negedge clk); #1;
        check("write_busy_cycles", 64'(busy_cnt[0] - b), 64'd257);
        check("write_no_rdy", 64'(rdy_cnt[0] - r), 64'd0);
        check("write_mdc_rises", 64'(rise_cnt[0] - f), 64'd64);
        check("write_bitstream", stream[0], {32'hFFFF_FFFF, 32'h5F8A_1234});

        // C22 read with start held high, then back-to-back C45 read-increment.
        @(posedge clk); #2;
        tdata0 = 32'h6F8A_0000; phy_next[0] = 16'hBEEF; start0 = 1'b1;
        r = rdy_cnt[0];
        wait_k(0, 1, "read_accept");
        tdata0 = 32'h2184_0000; phy_next[0] = 16'h0001;
        wait_k(0, nlen(0) + 2, "read_done");
        @(negedge clk); #1;
        check("read_rd_data", 64'(rd0), 64'h BEEF);
        check("read_rdy_at_busy_fall", 64'({rdy0, busy0}), 64'b10);
        wait_k(0, 1, "b2b_accept");
        start0 = 1'b0;
        check("b2b_busy_again", 64'(busy0), 64'd1);
        wait_k(0, nlen(0) + 2, "c45_read_done");
        @(negedge clk); #1;
        check("c45_rd_data", 64'(rd0), 64'h0001);
        check("c45_rdy", 64'(rdy0), 64'd1);
        check("read_rdy_pulses", 64'(rdy_cnt[0] - r), 64'd2);
        repeat (3) @(negedge clk);
        #1 check("idle_mdc_low", 64'({mdc0, busy0, rdy0}), 64'd0);

        // C45 address on the DIV=1, no-preamble instance.
        @(posedge clk); #2;
        tdata1 = 32'h0086_ABCD; start1 = 1'b1;
        b = busy_cnt[1]; r = rdy_cnt[1]; f = rise_cnt[1];
        @(posedge clk); #2 start1 = 1'b0;
        wait_k(1, nlen(1) + 2, "c45_addr_done");
        @(negedge clk); #1;
        check("c45_addr_busy_cycles", 64'(busy_cnt[1] - b), 64'd65);
        check("c45_addr_mdc_rises", 64'(rise_cnt[1] - f), 64'd32);
        check("c45_addr_bitstream", 64'(stream[1][31:0]), 64'h0086_ABCD);
        check("c45_addr_no_rdy", 64'(rdy_cnt[1] - r), 64'd0);

        // Reset during DAT bit 5 of a read, then a fresh read.
        @(posedge clk); #2;
        tdata0 = 32'h6F8A_0000; phy_next[0] = 16'h1234; start0 = 1'b1;
        r = rdy_cnt[0];
        @(posedge clk); #2 start0 = 1'b0;
        wait_k(0, 2 + (PRE0 + 16 + 5) * 2 * DIV0 + 1, "abort_reach_dat5");
        reset = 1'b0;
        #1 check("abort_async_clear", 64'({rd0, rdy0, busy0, mdc0, oe0, out0}), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        check("abort_no_rdy", 64'(rdy_cnt[0] - r), 64'd0);
        @(posedge clk); #2;
        tdata0 = 32'h6F8A_0000; phy_next[0] = 16'hA5C3; start0 = 1'b1;
        @(posedge clk); #2 start0 = 1'b0;
        wait_k(0, nlen(0) + 2, "after_reset_read_done");
        @(negedge clk); #1;
        check("after_reset_rd_data", 64'(rd0), 64'hA5C3);
        check("after_reset_rdy", 64'(rdy0), 64'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
